// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: 8N1 UART transmitter with optional parity, 1 or 2 stop bits,
// and a one-entry holding buffer so one byte can queue behind the frame in flight.
module uart_tx_serializer #(
  parameter int CLKS_PER_BIT = 434,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_tx_dv,
  input  logic [7:0] i_tx_byte,
  output logic       o_tx_serial,
  output logic       o_tx_active,
  output logic       o_tx_done,
  output logic       o_tx_ready,
  output logic       o_overrun
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BAUD_MAX = CW'(CLKS_PER_BIT - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0] idx_q, idx_d;
  logic stop_q, stop_d;
  logic [7:0] shift_q, shift_d, hold_q, hold_d;
  logic hold_valid_q, hold_valid_d;
  logic serial_q, serial_d, active_q, active_d, done_q, done_d;
  logic ready_q, ready_d, overrun_q, overrun_d;
  logic bit_end, launch;
  assign bit_end = baud_q == BAUD_MAX;
  assign launch = state_q == IDLE || state_q == DONE;
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    hold_d = hold_q;
    hold_valid_d = hold_valid_q;
    overrun_d = 1'b0;
    baud_d = (launch || bit_end) ? '0 : baud_q + 1'b1;
    idx_d = (state_q == DATA && bit_end) ? idx_q + 3'd1 : idx_q;
    stop_d = state_q == STOP && (stop_q || bit_end);
    case (state_q)
      IDLE, DONE: begin
        state_d = (hold_valid_q || i_tx_dv) ? START : IDLE;
        shift_d = hold_valid_q ? hold_q : (i_tx_dv ? i_tx_byte : shift_q);
        hold_valid_d = hold_valid_q && i_tx_dv;
        hold_d = (hold_valid_q && i_tx_dv) ? i_tx_byte : hold_q;
      end
      START:  state_d = bit_end ? DATA : START;
      DATA:   state_d = (bit_end && idx_q == 3'd7) ? (PARITY_EN != 0 ? PARITY : STOP) : DATA;
      PARITY: state_d = bit_end ? STOP : PARITY;
      STOP:   state_d = (bit_end && (stop_q || STOP_BITS == 1)) ? DONE : STOP;
      default: state_d = IDLE;
    endcase
    // Mid-frame strobes fill the empty buffer; a strobe against a full buffer is dropped.
    if (!launch && i_tx_dv) begin
      hold_valid_d = 1'b1;
      hold_d = hold_valid_q ? hold_q : i_tx_byte;
      overrun_d = hold_valid_q;
    end
    serial_d = state_d == START ? 1'b0 :
               state_d == DATA ? shift_d[idx_d] :
               state_d == PARITY ? (^shift_d) ^ 1'(PARITY_ODD) : 1'b1;
    active_d = state_d == START || state_d == DATA || state_d == PARITY || state_d == STOP;
    done_d = state_d == DONE;
    ready_d = ~hold_valid_d;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      baud_q <= '0;
      idx_q <= '0;
      stop_q <= 1'b0;
      shift_q <= '0;
      hold_q <= '0;
      hold_valid_q <= 1'b0;
      serial_q <= 1'b1;
      active_q <= 1'b0;
      done_q <= 1'b0;
      ready_q <= 1'b1;
      overrun_q <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q <= baud_d;
      idx_q <= idx_d;
      stop_q <= stop_d;
      shift_q <= shift_d;
      hold_q <= hold_d;
      hold_valid_q <= hold_valid_d;
      serial_q <= serial_d;
      active_q <= active_d;
      done_q <= done_d;
      ready_q <= ready_d;
      overrun_q <= overrun_d;
    end
  end
  assign o_tx_serial = serial_q;
  assign o_tx_active = active_q;
  assign o_tx_done = done_q;
  assign o_tx_ready = ready_q;
  assign o_overrun = overrun_q;
endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb_uart_tx_serializer: four differently configured transmitters on shared inputs,
// checked against a frame-timeline model plus fixed waveform tables.
module tb_uart_tx_serializer;
  logic clk = 1'b0, reset = 1'b0, dv = 1'b0;
  logic [7:0] b = 8'h00;
  logic [3:0] ser, act, dn, rdy, ov;
  always #5 clk = ~clk;
  uart_tx_serializer #(.CLKS_PER_BIT(4)) d0 (.clk(clk), .reset(reset), .i_tx_dv(dv), .i_tx_byte(b),
    .o_tx_serial(ser[0]), .o_tx_active(act[0]), .o_tx_done(dn[0]), .o_tx_ready(rdy[0]), .o_overrun(ov[0]));
  uart_tx_serializer #(.CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) d1 (.clk(clk), .reset(reset),
    .i_tx_dv(dv), .i_tx_byte(b), .o_tx_serial(ser[1]), .o_tx_active(act[1]), .o_tx_done(dn[1]), .o_tx_ready(rdy[1]), .o_overrun(ov[1]));
  uart_tx_serializer #(.CLKS_PER_BIT(5), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) d2 (.clk(clk), .reset(reset),
    .i_tx_dv(dv), .i_tx_byte(b), .o_tx_serial(ser[2]), .o_tx_active(act[2]), .o_tx_done(dn[2]), .o_tx_ready(rdy[2]), .o_overrun(ov[2]));
  uart_tx_serializer #(.CLKS_PER_BIT(4), .STOP_BITS(2)) d3 (.clk(clk), .reset(reset), .i_tx_dv(dv), .i_tx_byte(b),
    .o_tx_serial(ser[3]), .o_tx_active(act[3]), .o_tx_done(dn[3]), .o_tx_ready(rdy[3]), .o_overrun(ov[3]));
  localparam int CC[4] = '{4, 4, 5, 4};
  localparam int PE[4] = '{0, 1, 1, 0};
  localparam int PO[4] = '{0, 0, 1, 0};
  localparam int SB[4] = '{1, 1, 2, 2};
  typedef struct {logic [7:0] byt; int dut; int cyc; logic s; logic a; logic d;} vec_t;
  vec_t tbl[34];
  int checks = 0, errors = 0, e = 0, sedge = 0;
  bit have[4], hv[4], eov[4];
  int ts[4];
  logic [7:0] fb[4], hb[4];
  logic [4:0] lg[4][0:99];
  task automatic chk(input string n, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", n, got, exp);
    end
  endtask
  function automatic logic fbit(input int d, input int k);
    logic [7:0] x;
    x = fb[d];
    if (k == 0) return 1'b0;
    if (k <= 8) return x[k-1];
    if (k == 9 && PE[d] != 0) return (^x) ^ PO[d][0];
    return 1'b1;
  endfunction
  function automatic int flen(input int d);
    return (9 + PE[d] + SB[d]) * CC[d];
  endfunction
  task automatic model_reset();
    for (int d = 0; d < 4; d++) begin
      have[d] = 0; hv[d] = 0; eov[d] = 0; ts[d] = 0;
    end
  endtask
  // One sampling edge: a frame occupies ts..ts+L-1 and its done cycle is ts+L.
  task automatic model_step(input logic v, input logic [7:0] x);
    for (int d = 0; d < 4; d++) begin
      bit free;
      eov[d] = 0;
      free = !have[d] || e >= ts[d] + flen(d);
      if (free) begin
        if (hv[d]) begin
          fb[d] = hb[d]; ts[d] = e + 1; have[d] = 1;
          if (v) hb[d] = x; else hv[d] = 0;
        end else if (v) begin
          fb[d] = x; ts[d] = e + 1; have[d] = 1;
        end
      end else if (v) begin
        if (!hv[d]) begin hv[d] = 1; hb[d] = x; end
        else eov[d] = 1;
      end
    end
  endtask
  task automatic compare();
    for (int d = 0; d < 4; d++) begin
      int o;
      logic es, ea, ed;
      o = e + 1 - ts[d];
      es = 1'b1; ea = 1'b0; ed = 1'b0;
      if (have[d] && o >= 0 && o < flen(d)) begin ea = 1'b1; es = fbit(d, o / CC[d]); end
      else if (have[d] && o == flen(d)) ed = 1'b1;
      chk($sformatf("d%0d c%0d serial", d, e + 1), ser[d], es);
      chk($sformatf("d%0d c%0d active", d, e + 1), act[d], ea);
      chk($sformatf("d%0d c%0d done", d, e + 1), dn[d], ed);
      chk($sformatf("d%0d c%0d ready", d, e + 1), rdy[d], !hv[d]);
      chk($sformatf("d%0d c%0d overrun", d, e + 1), ov[d], eov[d]);
    end
  endtask
  task automatic tick(input logic v, input logic [7:0] x);
    int j;
    dv = v; b = x;
    @(posedge clk);
    model_step(v, x);
    @(negedge clk);
    compare();
    j = e + 1 - sedge;
    if (j >= 0 && j < 100)
      for (int d = 0; d < 4; d++) lg[d][j] = {ser[d], act[d], dn[d], rdy[d], ov[d]};
    e++;
  endtask
  task automatic run_scn(input logic [7:0] x);
    sedge = e;
    tick(1'b1, x);
    repeat (149) tick(1'b0, 8'h00);
    for (int i = 0; i < 34; i++)
      if (tbl[i].byt == x) begin
        chk($sformatf("tbl%0d d%0d c%0d serial", i, tbl[i].dut, tbl[i].cyc), lg[tbl[i].dut][tbl[i].cyc][4], tbl[i].s);
        chk($sformatf("tbl%0d d%0d c%0d active", i, tbl[i].dut, tbl[i].cyc), lg[tbl[i].dut][tbl[i].cyc][3], tbl[i].a);
        chk($sformatf("tbl%0d d%0d c%0d done", i, tbl[i].dut, tbl[i].cyc), lg[tbl[i].dut][tbl[i].cyc][2], tbl[i].d);
      end
  endtask
  initial begin
    tbl = '{
      '{8'h41, 0, 1, 0, 1, 0}, '{8'h41, 0, 4, 0, 1, 0}, '{8'h41, 0, 5, 1, 1, 0}, '{8'h41, 0, 8, 1, 1, 0},
      '{8'h41, 0, 9, 0, 1, 0}, '{8'h41, 0, 29, 1, 1, 0}, '{8'h41, 0, 33, 0, 1, 0}, '{8'h41, 0, 36, 0, 1, 0},
      '{8'h41, 0, 37, 1, 1, 0}, '{8'h41, 0, 40, 1, 1, 0}, '{8'h41, 0, 41, 1, 0, 1}, '{8'h41, 0, 42, 1, 0, 0},
      '{8'hA5, 0, 41, 1, 0, 1}, '{8'hA5, 1, 33, 1, 1, 0}, '{8'hA5, 1, 37, 0, 1, 0}, '{8'hA5, 1, 40, 0, 1, 0},
      '{8'hA5, 1, 41, 1, 1, 0}, '{8'hA5, 1, 44, 1, 1, 0}, '{8'hA5, 1, 45, 1, 0, 1}, '{8'hA5, 1, 46, 1, 0, 0},
      '{8'hA5, 2, 5, 0, 1, 0}, '{8'hA5, 2, 6, 1, 1, 0}, '{8'hA5, 2, 11, 0, 1, 0}, '{8'hA5, 2, 46, 1, 1, 0},
      '{8'hA5, 2, 50, 1, 1, 0}, '{8'hA5, 2, 60, 1, 1, 0}, '{8'hA5, 2, 61, 1, 0, 1}, '{8'hA5, 2, 62, 1, 0, 0},
      '{8'hA5, 3, 45, 1, 0, 1},
      '{8'hFF, 3, 4, 0, 1, 0}, '{8'hFF, 3, 5, 1, 1, 0}, '{8'hFF, 3, 44, 1, 1, 0}, '{8'hFF, 3, 45, 1, 0, 1},
      '{8'hFF, 3, 46, 1, 0, 0}};
    model_reset();
    repeat (2) @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("d%0d reset serial", d), ser[d], 1'b1);
      chk($sformatf("d%0d reset active", d), act[d], 1'b0);
      chk($sformatf("d%0d reset done", d), dn[d], 1'b0);
      chk($sformatf("d%0d reset ready", d), rdy[d], 1'b1);
      chk($sformatf("d%0d reset overrun", d), ov[d], 1'b0);
    end
    reset = 1'b1;
    run_scn(8'h41);
    run_scn(8'hA5);
    run_scn(8'hFF);
    // Queued byte: 0x34 waits in the holding buffer behind 0x12.
    sedge = e;
    tick(1'b1, 8'h12);
    repeat (9) tick(1'b0, 8'h00);
    tick(1'b1, 8'h34);
    repeat (139) tick(1'b0, 8'h00);
    chk("queue ready c10", lg[0][10][1], 1'b1);
    chk("queue ready c11", lg[0][11][1], 1'b0);
    chk("queue ready c41", lg[0][41][1], 1'b0);
    chk("queue ready c42", lg[0][42][1], 1'b1);
    chk("queue done c41", lg[0][41][2], 1'b1);
    chk("queue serial c41", lg[0][41][4], 1'b1);
    chk("queue start c42", lg[0][42][4], 1'b0);
    chk("queue done c81", lg[0][81][2], 1'b0);
    chk("queue done c82", lg[0][82][2], 1'b1);
    // Overrun: the third strobe lands while 0x02 is held and must be dropped.
    sedge = e;
    tick(1'b1, 8'h01);
    repeat (4) tick(1'b0, 8'h00);
    tick(1'b1, 8'h02);
    tick(1'b1, 8'h03);
    repeat (143) tick(1'b0, 8'h00);
    chk("ovr c6", lg[0][6][0], 1'b0);
    chk("ovr c7", lg[0][7][0], 1'b1);
    chk("ovr c8", lg[0][8][0], 1'b0);
    chk("ovr frame2 bit0 c46", lg[0][46][4], 1'b0);
    chk("ovr frame2 bit1 c50", lg[0][50][4], 1'b1);
    // Reset in the middle of data bit 3 of d0.
    sedge = e;
    tick(1'b1, 8'h41);
    repeat (17) tick(1'b0, 8'h00);
    chk("pre-reset active", act[0], 1'b1);
    #2 reset = 1'b0;
    #1;
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("d%0d async reset serial", d), ser[d], 1'b1);
      chk($sformatf("d%0d async reset active", d), act[d], 1'b0);
      chk($sformatf("d%0d async reset done", d), dn[d], 1'b0);
    end
    model_reset();
    @(posedge clk);
    @(posedge clk);
    e += 2;
    @(negedge clk);
    reset = 1'b1;
    repeat (60) tick(1'b0, 8'h00);
    tick(1'b1, 8'h55);
    repeat (80) tick(1'b0, 8'h00);
    repeat (2000) tick($urandom_range(0, 7) == 0, 8'($urandom));
    repeat (2000) tick($urandom_range(0, 50) == 0, 8'($urandom));
    repeat (150) tick(1'b0, 8'h00);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
